sum_serial: RTL and testbench
=============================

// Module: sum_serial
// PURPOSE
// Parametrised multi-cycle two-operand adder/subtractor for the sum family.
// Adds or subtracts two W-bit unsigned operands CHUNK bits per clock, holding the
// carry in a register between chunks, and returns a W+1-bit result.
// Valid/ready handshakes on input and output let it sit between producers and consumers.
// PARAMETERS
// W      8  operand width in bits; W >= 2
// CHUNK  2  bits processed per cycle; 1 <= CHUNK <= W, W % CHUNK == 0 (elaboration error otherwise)
// STEPS = W/CHUNK (derived, not overridable)
// PORTS
// clk        in   1      clock, all state updates on rising edge
// rst        in   1      reset; synchronous, active-high
// in_valid   in   1      ft/st/sub valid this cycle
// in_ready   out  1      block can accept an operation (high only in IDLE)
// ft         in   W      first operand, unsigned
// st         in   W      second operand, unsigned
// sub        in   1      0: res = ft + st; 1: res = ft - st
// out_valid  out  1      res valid; held until accepted
// out_ready  in   1      consumer accepts res when out_valid & out_ready
// res        out  W+1    result; see arithmetic rules
// BEHAVIOUR
// - rst high at a rising edge: state=IDLE, out_valid=0, res=0, carry=0, count=0,
//   in_ready=1 after that edge; aborts any operation in progress; result is discarded.
// - FSM states: IDLE, RUN, DONE.
// - IDLE: in_ready=1. If in_valid=1: latch ft, st, and sub; set carry=sub and count=0; -> RUN.
//   If in_valid=0, stay IDLE.
// - RUN: in_ready=0. Each cycle, add chunk[count] of ft and chunk[count] of (sub ? ~st : st)
//   plus carry. Write the CHUNK sum bits to res[(count+1)*CHUNK-1 : count*CHUNK].
//   Carry-out -> carry. count++.
//   When count==STEPS-1: write carry-out to res[W], set out_valid=1, -> DONE.
// - DONE: out_valid=1 and res stable. If out_ready=1: out_valid=0 -> IDLE.
//   A new operation can be accepted the following cycle; no bypass from DONE.
// - Latency: accept at edge k -> out_valid rises after edge k+STEPS.
//   Throughput: one op per STEPS+2 cycles with out_ready tied high.
// - Add: res = ft + st exactly; res[W] = carry out.
// - Subtract: res[W-1:0] = (ft - st) mod 2^W.
//   res[W] = 1 iff ft >= st (no borrow), 0 if borrow.
// - in_valid, ft, st, sub are ignored outside IDLE; operands are not re-sampled mid-op.
// - out_ready is ignored outside DONE.
// - res upper bits not yet written in RUN hold the previous op's values; only sampled with out_valid.
// - rst and in_valid at the same edge: reset wins, nothing accepted.
// - rst during DONE with out_ready=1: reset wins, result lost.
// TESTING (W=8, CHUNK=2 unless stated)
// 1. Reset, then ft=8'h03 st=8'h02 sub=0 -> after 4 cycles out_valid=1, res=9'h005; in_ready=0 throughout.
// 2. ft=8'hFF st=8'h01 sub=0 -> res=9'h100 (carry ripples across all chunks).
// 3. ft=8'h05 st=8'h07 sub=1 -> res=9'h0FE (borrow); ft=8'h07 st=8'h05 sub=1 -> res=9'h102.
// 4. out_ready=0 for 5 cycles in DONE -> out_valid and res held; in_valid pulses ignored.
//    Then out_ready=1 -> IDLE next cycle.
// 5. rst asserted in 2nd RUN cycle -> next cycle IDLE, out_valid=0, res=0.
//    A following op ft=8'h10 st=8'h20 returns 9'h030.
// 6. Sweep CHUNK in {1,2,4,8} with random ft/st/sub vs reference model.
//    Latency must equal STEPS; with out_ready=1, back-to-back in_valid gives one op per STEPS+2 cycles.

Source files
------------

// File: rtl/sum_serial.sv
// Serial W-bit unsigned add/subtract, CHUNK bits per cycle through a registered carry; W+1-bit result.
// Result valid STEPS cycles after accept and held until out_ready; new work accepted only while idle.
module sum_serial #(
  parameter int W     = 8,
  parameter int CHUNK = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] ft,
  input  logic [W-1:0] st,
  input  logic         sub,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W:0]   res
);

  localparam int STEPS = W / CHUNK;
  localparam int CW    = (STEPS > 1) ? $clog2(STEPS) : 1;
  localparam logic [CW-1:0] LAST = CW'(STEPS - 1);

  if (W < 2 || CHUNK < 1 || CHUNK > W || (W % CHUNK) != 0) begin : g_bad_params
    $error("sum_serial: W must be >= 2 and a multiple of CHUNK, with 1 <= CHUNK <= W");
  end

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t         state;
  state_t         state_nxt;
  logic [W-1:0]   ft_q;
  logic [W-1:0]   st_q;
  logic           carry;
  logic [CW-1:0]  count;
  logic           last;
  logic [CHUNK:0] chunk_sum;

  assign last = (count == LAST);

  // Subtraction is ft + ~st + 1: st is inverted at accept and carry seeded with sub.
  assign chunk_sum = {1'b0, ft_q[count*CHUNK +: CHUNK]}
                   + {1'b0, st_q[count*CHUNK +: CHUNK]}
                   + {{CHUNK{1'b0}}, carry};

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_nxt = RUN;
      end
      RUN: begin
        if (last) state_nxt = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ft_q  <= '0;
      st_q  <= '0;
      carry <= 1'b0;
      count <= '0;
      res   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            ft_q  <= ft;
            st_q  <= sub ? ~st : st;
            carry <= sub;
            count <= '0;
          end
        end
        RUN: begin
          res[count*CHUNK +: CHUNK] <= chunk_sum[CHUNK-1:0];
          carry <= chunk_sum[CHUNK];
          count <= count + 1'b1;
          if (last) res[W] <= chunk_sum[CHUNK];
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_sum_serial.sv
// Scoreboard bench: four sum_serial instances (CHUNK 1,2,4,8); directed scenarios on CHUNK=2, then a vector sweep on all.
module tb_sum_serial;

  typedef struct {
    logic [8:0] exp;
    int         acc;
  } ent_t;

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic       s;
    logic [8:0] e;
  } vec_t;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic [3:0]      in_valid_v  = '0;
  logic [3:0]      in_ready_v;
  logic [3:0][7:0] ft_v        = '0;
  logic [3:0][7:0] st_v        = '0;
  logic [3:0]      sub_v       = '0;
  logic [3:0]      out_valid_v;
  logic [3:0]      out_ready_v = '0;
  logic [3:0][8:0] res_v;
  logic [3:0][8:0] exp_v       = '0;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  bit tp_chk   = 1'b0;

  vec_t vecs [10] = '{
    '{8'hA5, 8'h5A, 1'b0, 9'h0FF},
    '{8'h80, 8'h80, 1'b0, 9'h100},
    '{8'hFF, 8'hFF, 1'b0, 9'h1FE},
    '{8'h00, 8'h01, 1'b1, 9'h0FF},
    '{8'h00, 8'h00, 1'b1, 9'h100},
    '{8'hFF, 8'hFF, 1'b1, 9'h100},
    '{8'hC8, 8'h37, 1'b1, 9'h191},
    '{8'h3C, 8'hC3, 1'b0, 9'h0FF},
    '{8'h01, 8'hFF, 1'b1, 9'h002},
    '{8'h7F, 8'h01, 1'b0, 9'h080}
  };

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic timeout(input string name);
    checks++;
    failures++;
    $display("FAIL %s: timed out waiting for DUT (cycle %0d)", name, cyc);
  endtask

  for (genvar g = 0; g < 4; g++) begin : g_inst
    localparam int CH    = 1 << g;
    localparam int STEPS = 8 / CH;

    sum_serial #(.W(8), .CHUNK(CH)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid_v[g]),
      .in_ready  (in_ready_v[g]),
      .ft        (ft_v[g]),
      .st        (st_v[g]),
      .sub       (sub_v[g]),
      .out_valid (out_valid_v[g]),
      .out_ready (out_ready_v[g]),
      .res       (res_v[g])
    );

    ent_t q[$];
    logic prev_ov  = 1'b0;
    int   prev_acc = -1;

    always @(negedge clk) begin
      if (rst) begin
        q.delete();
        prev_acc <= -1;
        prev_ov  <= 1'b0;
      end else begin
        if (out_valid_v[g] && !prev_ov) begin
          if (q.size() == 0) chk($sformatf("spurious_out_c%0d", CH), 32'd1, 32'd0);
          else chk($sformatf("latency_c%0d", CH), cyc - q[0].acc, STEPS);
        end
        if (out_valid_v[g] && out_ready_v[g]) begin
          if (q.size() == 0) chk($sformatf("unexpected_res_c%0d", CH), 32'd1, 32'd0);
          else chk($sformatf("res_c%0d", CH), res_v[g], q.pop_front().exp);
        end
        if (in_valid_v[g] && in_ready_v[g]) begin
          if (tp_chk && prev_acc >= 0)
            chk($sformatf("throughput_c%0d", CH), cyc + 1 - prev_acc, STEPS + 2);
          prev_acc <= tp_chk ? cyc + 1 : -1;
          q.push_back('{exp_v[g], cyc + 1});
        end
        prev_ov <= out_valid_v[g];
      end
    end
  end

  // Present an op on instance k and return just after the edge that accepts it; in_valid stays high.
  task automatic issue(input int k, input logic [7:0] a, input logic [7:0] b,
                       input logic s, input logic [8:0] e);
    int n;
    ft_v[k]       = a;
    st_v[k]       = b;
    sub_v[k]      = s;
    exp_v[k]      = e;
    in_valid_v[k] = 1'b1;
    n = 0;
    @(negedge clk);
    while (!in_ready_v[k] && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) timeout($sformatf("accept_%0d", k));
    @(posedge clk);
    #1;
  endtask

  task automatic wait_idle(input int k);
    int n;
    n = 0;
    while (!in_ready_v[k] && n < 200) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (n >= 200) timeout($sformatf("idle_%0d", k));
  endtask

  task automatic run_sweep(input int k);
    for (int i = 0; i < 10; i++) issue(k, vecs[i].a, vecs[i].b, vecs[i].s, vecs[i].e);
    in_valid_v[k] = 1'b0;
  endtask

  initial begin
    int n;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    for (int k = 0; k < 4; k++) begin
      chk("rst_in_ready", in_ready_v[k], 1'b1);
      chk("rst_out_valid", out_valid_v[k], 1'b0);
      chk("rst_res", res_v[k], 9'h000);
    end
    out_ready_v = '1;

    // Basic add; in_ready low while running.
    issue(1, 8'h03, 8'h02, 1'b0, 9'h005);
    in_valid_v[1] = 1'b0;
    for (int i = 0; i < 4; i++) begin
      chk("busy_in_ready", in_ready_v[1], 1'b0);
      @(posedge clk);
      #1;
    end
    wait_idle(1);

    // Carry ripple, then subtract with and without borrow.
    issue(1, 8'hFF, 8'h01, 1'b0, 9'h100);
    issue(1, 8'h05, 8'h07, 1'b1, 9'h0FE);
    issue(1, 8'h07, 8'h05, 1'b1, 9'h102);
    in_valid_v[1] = 1'b0;
    wait_idle(1);

    // Consumer stall in DONE: result held, new requests ignored.
    out_ready_v[1] = 1'b0;
    issue(1, 8'h12, 8'h34, 1'b0, 9'h046);
    in_valid_v[1] = 1'b0;
    n = 0;
    while (!out_valid_v[1] && n < 50) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (n >= 50) timeout("stall_out_valid");
    ft_v[1] = 8'hFF;
    st_v[1] = 8'hFF;
    for (int i = 0; i < 5; i++) begin
      chk("hold_out_valid", out_valid_v[1], 1'b1);
      chk("hold_res", res_v[1], 9'h046);
      chk("hold_in_ready", in_ready_v[1], 1'b0);
      in_valid_v[1] = ~in_valid_v[1];
      @(posedge clk);
      #1;
    end
    in_valid_v[1]  = 1'b0;
    out_ready_v[1] = 1'b1;
    @(posedge clk);
    #1;
    chk("release_in_ready", in_ready_v[1], 1'b1);
    chk("release_out_valid", out_valid_v[1], 1'b0);

    // Reset in the second RUN cycle aborts the op.
    issue(1, 8'h55, 8'h11, 1'b0, 9'h066);
    in_valid_v[1] = 1'b0;
    @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    chk("abort_in_ready", in_ready_v[1], 1'b1);
    chk("abort_out_valid", out_valid_v[1], 1'b0);
    chk("abort_res", res_v[1], 9'h000);
    issue(1, 8'h10, 8'h20, 1'b0, 9'h030);
    in_valid_v[1] = 1'b0;
    wait_idle(1);

    // Reset and in_valid on the same edge: nothing accepted.
    ft_v[1] = 8'h01;
    st_v[1] = 8'h01;
    in_valid_v[1] = 1'b1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    in_valid_v[1] = 1'b0;
    chk("rst_vs_valid_in_ready", in_ready_v[1], 1'b1);
    @(posedge clk);
    #1;
    chk("rst_vs_valid_idle", in_ready_v[1], 1'b1);

    // Back-to-back sweep across all chunk widths.
    tp_chk = 1'b1;
    out_ready_v = '1;
    fork
      run_sweep(0);
      run_sweep(1);
      run_sweep(2);
      run_sweep(3);
    join
    repeat (30) @(posedge clk);
    #1;
    chk("drain_c1", g_inst[0].q.size(), 0);
    chk("drain_c2", g_inst[1].q.size(), 0);
    chk("drain_c4", g_inst[2].q.size(), 0);
    chk("drain_c8", g_inst[3].q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
